// File: rtl/model_scalar_float_adder_arbiter.sv
// Round-robin arbiter sharing one scalar float adder among NUM_REQ requesters.
// Each requester gets a one-entry operand buffer and a pending flag.
module model_scalar_float_adder_arbiter #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int NUM_REQ      = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ_START,
  input  logic [NUM_REQ-1:0]           REQ_OPERATION,
  input  logic [NUM_REQ*DATA_SIZE-1:0] REQ_DATA_A_IN,
  input  logic [NUM_REQ*DATA_SIZE-1:0] REQ_DATA_B_IN,
  output logic [NUM_REQ-1:0]           REQ_READY,
  output logic [NUM_REQ-1:0]           REQ_BUSY,
  output logic [DATA_SIZE-1:0]         REQ_DATA_OUT,
  output logic                         UNIT_START,
  input  logic                         UNIT_READY,
  output logic                         UNIT_OPERATION,
  output logic [DATA_SIZE-1:0]         UNIT_DATA_A_OUT,
  output logic [DATA_SIZE-1:0]         UNIT_DATA_B_OUT,
  input  logic [DATA_SIZE-1:0]         UNIT_DATA_IN
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CONTROL_SIZE < 1) begin : g_bad_param
    $error("model_scalar_float_adder_arbiter: illegal parameters");
  end

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   pending;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        grant;
  logic [NUM_REQ-1:0]   buf_op;
  logic [DATA_SIZE-1:0] buf_a [NUM_REQ];
  logic [DATA_SIZE-1:0] buf_b [NUM_REQ];

  logic                 done;
  logic [NUM_REQ-1:0]   clr;
  logic [NUM_REQ-1:0]   take;
  logic [NUM_REQ-1:0]   pending_n;
  logic [PW-1:0]        pick;
  logic                 found;
  logic [PW-1:0]        nxt;

  assign REQ_BUSY = pending;

  // UNIT_READY during the UNIT_START cycle belongs to no request
  always_comb begin
    done = (state == WAIT) && !UNIT_START && UNIT_READY;
    clr  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      clr[k] = done && (grant == PW'(k));
    end
    take      = REQ_START & ~(pending & ~clr);
    pending_n = (pending & ~clr) | REQ_START;
    nxt       = (grant == LAST) ? '0 : grant + PW'(1);
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && pending[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      pending         <= '0;
      rr_ptr          <= '0;
      grant           <= '0;
      buf_op          <= '0;
      UNIT_START      <= 1'b0;
      UNIT_OPERATION  <= 1'b0;
      UNIT_DATA_A_OUT <= '0;
      UNIT_DATA_B_OUT <= '0;
      REQ_READY       <= '0;
      REQ_DATA_OUT    <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        buf_a[k] <= '0;
        buf_b[k] <= '0;
      end
    end else begin
      REQ_READY  <= '0;
      UNIT_START <= 1'b0;
      pending    <= pending_n;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (take[k]) begin
          buf_op[k] <= REQ_OPERATION[k];
          buf_a[k]  <= REQ_DATA_A_IN[k*DATA_SIZE +: DATA_SIZE];
          buf_b[k]  <= REQ_DATA_B_IN[k*DATA_SIZE +: DATA_SIZE];
        end
      end
      unique case (state)
        IDLE: begin
          if (|pending) begin
            grant           <= pick;
            UNIT_OPERATION  <= buf_op[pick];
            UNIT_DATA_A_OUT <= buf_a[pick];
            UNIT_DATA_B_OUT <= buf_b[pick];
            UNIT_START      <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            REQ_DATA_OUT     <= UNIT_DATA_IN;
            REQ_READY[grant] <= 1'b1;
            rr_ptr           <= nxt;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/model_scalar_float_adder_arbiter.md
MODEL_SCALAR_FLOAT_ADDER_ARBITER -- requirements
Module: model_scalar_float_adder_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_SIZE, 64, operand/result width; CONTROL_SIZE, 64, passed-through control width (unused internally); NUM_REQ, 4, number of requesters (legal 2..8).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-low.
REQ-004 REQ_START  in  NUM_REQ  per-requester one-cycle request pulse.
REQ-005 REQ_OPERATION  in  NUM_REQ  per-requester operation (0 add, 1 subtract), sampled with REQ_START.
REQ-006 REQ_DATA_A_IN, REQ_DATA_B_IN  in  NUM_REQ*DATA_SIZE each  operands; requester k occupies bits [k*DATA_SIZE +: DATA_SIZE].
REQ-007 REQ_READY  out  NUM_REQ  per-requester one-cycle completion pulse.
REQ-008 REQ_BUSY  out  NUM_REQ  per-requester pending-or-in-service flag.
REQ-009 REQ_DATA_OUT  out  DATA_SIZE  shared result bus, valid only in the cycle some REQ_READY bit is 1.
REQ-010 UNIT_START  out  1  start pulse to the shared scalar float adder.
REQ-011 UNIT_READY  in  1  completion pulse from the shared adder.
REQ-012 UNIT_OPERATION  out  1; UNIT_DATA_A_OUT, UNIT_DATA_B_OUT  out  DATA_SIZE  operands driven to the adder.
REQ-013 UNIT_DATA_IN  in  DATA_SIZE  adder result.

Function
REQ-014 On an edge with REQ_START[k]=1 and pending[k]=0, the block SHALL capture requester k's operation and operands into buffer k and set pending[k].
REQ-015 A REQ_START[k] pulse while pending[k]=1 SHALL be ignored; the buffer and the in-flight operation are unchanged.
REQ-016 REQ_BUSY[k] SHALL equal pending[k]; pending[k] stays set through service and clears on the edge that asserts REQ_READY[k].
REQ-017 FSM SHALL have two states: IDLE and WAIT.
REQ-018 IDLE: if any pending bit is set, the block SHALL on the next edge select grant by round-robin, load UNIT_OPERATION/UNIT_DATA_A_OUT/UNIT_DATA_B_OUT from buffer[grant], assert UNIT_START for exactly one cycle, and go to WAIT; otherwise it stays in IDLE.
REQ-019 Round-robin: search starts at index rr_ptr and wraps modulo NUM_REQ; the first pending index wins.
REQ-020 WAIT: UNIT_READY SHALL be ignored in the cycle UNIT_START is high; on a later edge with UNIT_READY=1, register REQ_DATA_OUT<=UNIT_DATA_IN, pulse REQ_READY[grant] for one cycle, clear pending[grant], set rr_ptr<=(grant+1) mod NUM_REQ, and return to IDLE.
REQ-021 UNIT_READY in IDLE SHALL be ignored.
REQ-022 UNIT operand outputs SHALL hold stable from UNIT_START through the UNIT_READY edge.
REQ-023 Latency: REQ_START sampled at edge E0 with unit idle -> UNIT_START high after E1; UNIT_READY sampled at edge En -> REQ_READY high after En.
REQ-024 Simultaneous: REQ_START[k] on the same edge pending[k] clears SHALL set pending[k] again with new operands (set wins); a request arriving while WAIT is serviced after current completion.
REQ-025 After leaving WAIT, the block SHALL spend at least one cycle in IDLE before the next UNIT_START.
REQ-026 At most one REQ_READY bit SHALL be high in any cycle.

Reset
REQ-027 While RST=0: state=IDLE, pending=0, rr_ptr=0, grant=0, buffers=0, UNIT_START=0, UNIT_OPERATION=0, UNIT_DATA_A_OUT=0, UNIT_DATA_B_OUT=0, REQ_READY=0, REQ_DATA_OUT=0.
REQ-028 Reset asserted mid-operation SHALL immediately abandon the in-flight request without a REQ_READY pulse; a UNIT_READY after reset release, while in IDLE, is ignored.

Verification
REQ-029 Single: REQ_START[2], A=5, B=3, op=0; adder returns 8 three cycles after UNIT_START -> UNIT_START one cycle after E1 with A=5,B=3; REQ_READY=4'b0100 for one cycle, REQ_DATA_OUT=8; REQ_BUSY[2] 1 then 0.
REQ-030 Contention: REQ_START=4'b1111 same edge, rr_ptr=0 -> service order 0,1,2,3; exactly four REQ_READY pulses, each with its own result.
REQ-031 Fairness: requesters 0 and 1 re-request immediately on every REQ_READY -> grants alternate 0,1,0,1; no requester starves.
REQ-032 Duplicate: REQ_START[1] again while REQ_BUSY[1]=1 with different operands -> ignored; single REQ_READY[1] with original result.
REQ-033 Set-wins: REQ_START[3] on the REQ_READY[3] edge -> REQ_BUSY[3] stays 1, second operation serviced with new operands.
REQ-034 Reset: RST=0 during WAIT with REQ_BUSY=4'b0011 -> all outputs 0 immediately; late UNIT_READY after release produces no REQ_READY.
